if_fetch_unit: RTL and testbench

Instruction-fetch front end of the ARM pipeline. It holds the program counter and fetches one instruction at a time from instruction memory over a req/ack handshake. Each cycle it presents `pc_out` and `instruction_out` to the IF/ID pipeline register. It responds to pipeline freeze by holding a fetched instruction, and to branch redirects by discarding stale fetches and emitting bubbles (the never-execute NOP) until the new stream arrives.

---
 rtl/if_fetch_unit.sv | 133 +++++++++++++
 tb/tb_if_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: holds the PC, fetches over a req/ack handshake,
// buffers a fetch that completes under freeze, and drains stale fetches on redirect.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'hF000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instruction_out,
   output logic        fetch_valid
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ST_RST_IDLE = 2'd0,
      ST_REQ      = 2'd1,
      ST_HOLD     = 2'd2,
      ST_DRAIN    = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [XLEN-1:0]   pc, pc_nxt;
   logic [XLEN-1:0]   drain_addr, drain_addr_nxt;
   logic [XLEN-1:0]   hold_instr, hold_instr_nxt;
   logic [XLEN-1:0]   hold_pc, hold_pc_nxt;
   logic [XLEN-1:0]   pc_inc;

   assign pc_inc = pc + XLEN'(4);

   // State and datapath registers; synchronous reset returns to the idle state
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_RST_IDLE;
         pc         <= RESET_PC;
         drain_addr <= RESET_PC;
         hold_instr <= NOP;
         hold_pc    <= '0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         drain_addr <= drain_addr_nxt;
         hold_instr <= hold_instr_nxt;
         hold_pc    <= hold_pc_nxt;
      end
   end

   // Next-state and output logic; outputs follow the ack combinationally
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      drain_addr_nxt  = drain_addr;
      hold_instr_nxt  = hold_instr;
      hold_pc_nxt     = hold_pc;
      imem_req        = 1'b0;
      imem_addr       = pc;
      instruction_out = NOP;
      pc_out          = '0;
      fetch_valid     = 1'b0;

      unique case (state)
         ST_RST_IDLE: begin
            state_nxt = ST_REQ;
         end
         ST_REQ: begin
            imem_req = 1'b1;
            if (branch_taken) begin
               // Redirect wins; an ack this cycle is simply dropped
               pc_nxt = branch_addr;
               if (!imem_ack) begin
                  drain_addr_nxt = pc;
                  state_nxt      = ST_DRAIN;
               end
            end else if (imem_ack) begin
               instruction_out = imem_rdata;
               pc_out          = pc_inc;
               fetch_valid     = 1'b1;
               pc_nxt          = pc_inc;
               if (freeze) begin
                  hold_instr_nxt = imem_rdata;
                  hold_pc_nxt    = pc_inc;
                  state_nxt      = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (branch_taken) begin
               pc_nxt    = branch_addr;
               state_nxt = ST_REQ;
            end else begin
               instruction_out = hold_instr;
               pc_out          = hold_pc;
               fetch_valid     = 1'b1;
               if (!freeze) begin
                  state_nxt = ST_REQ;
               end
            end
         end
         ST_DRAIN: begin
            // Keep the abandoned request alive until memory completes it
            imem_req  = 1'b1;
            imem_addr = drain_addr;
            if (branch_taken) begin
               pc_nxt = branch_addr;
            end
            if (imem_ack) begin
               state_nxt = ST_REQ;
            end
         end
         default: begin
            state_nxt = ST_RST_IDLE;
         end
      endcase

      // Reset forces quiet outputs regardless of the current state
      if (rst) begin
         imem_req        = 1'b0;
         imem_addr       = RESET_PC;
         instruction_out = NOP;
         pc_out          = '0;
         fetch_valid     = 1'b0;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'hF000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instruction_out;
   logic        fetch_valid;

   int checks   = 0;
   int failures = 0;

   if_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .freeze          (freeze),
      .branch_taken    (branch_taken),
      .branch_addr     (branch_addr),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .fetch_valid     (fetch_valid)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_instr"}, instruction_out, NOP);
      check({tag, "_pc"}, pc_out, 32'h0);
      check({tag, "_valid"}, 32'(fetch_valid), 32'h0);
   endtask

   task automatic check_valid(input string tag, input logic [31:0] instr, input logic [31:0] pcv);
      check({tag, "_instr"}, instruction_out, instr);
      check({tag, "_pc"}, pc_out, pcv);
      check({tag, "_valid"}, 32'(fetch_valid), 32'h1);
   endtask

   task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
      check({tag, "_req"}, 32'(imem_req), 32'(req));
      if (req) check({tag, "_addr"}, imem_addr, addr);
   endtask

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Memory never acks without a request
   always @(negedge clk) begin
      if (!rst) begin
         assert (!(imem_ack && !imem_req))
         else begin
            failures++;
            $error("FAIL ack_without_req");
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
      imem_ack = 1'b0; imem_rdata = '0;

      // Reset held two cycles
      for (int i = 0; i < 2; i++) begin
         cyc(); #1;
         check("rst_req", 32'(imem_req), 32'h0);
         check("rst_addr", imem_addr, 32'h0);
         check_bubble("rst");
      end
      rst = 1'b0; #1;
      check("rel1_req", 32'(imem_req), 32'h0);
      check_bubble("rel1");
      cyc(); #1;
      check_req("rel2", 1'b1, 32'h0);

      // Zero-wait fetches at 0 and 4
      for (int i = 0; i < 2; i++) begin
         imem_ack = 1'b1; imem_rdata = 32'hE000_0000 | 32'(4 * i); #1;
         check_req("zw", 1'b1, 32'(4 * i));
         check_valid("zw", 32'hE000_0000 | 32'(4 * i), 32'(4 * i + 4));
         cyc();
      end

      // Freeze lands with the ack for 8, held three cycles
      freeze = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hE000_0008; #1;
      check_req("fz_ack", 1'b1, 32'h8);
      check_valid("fz_ack", 32'hE000_0008, 32'hC);
      cyc();
      imem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check_req("hold", 1'b0, 32'h0);
         check_valid("hold", 32'hE000_0008, 32'hC);
         cyc();
      end
      freeze = 1'b0; #1;
      check_valid("hold_rel", 32'hE000_0008, 32'hC);
      cyc(); #1;
      check_req("after_hold", 1'b1, 32'hC);

      // Fetch 0xC, then branch to 0x100 while 0x10 is outstanding
      imem_ack = 1'b1; imem_rdata = 32'hE000_000C; #1;
      check_valid("f0c", 32'hE000_000C, 32'h10);
      cyc();
      imem_ack = 1'b0; #1;
      check_req("wait10", 1'b1, 32'h10);
      check_bubble("wait10");
      cyc();
      branch_taken = 1'b1; branch_addr = 32'h100; #1;
      check_req("br", 1'b1, 32'h10);
      check_bubble("br");
      cyc();
      branch_taken = 1'b0; #1;
      check_req("drain1", 1'b1, 32'h10);
      check_bubble("drain1");
      cyc();
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
      check_req("drain2", 1'b1, 32'h10);
      check_bubble("drain2");
      cyc();
      imem_ack = 1'b0; #1;
      check_req("tgt100", 1'b1, 32'h100);

      // Branch to 0x200 in the same cycle as an ack
      imem_ack = 1'b1; imem_rdata = 32'hE000_0100;
      branch_taken = 1'b1; branch_addr = 32'h200; #1;
      check_bubble("br_ack");
      cyc();
      branch_taken = 1'b0; imem_ack = 1'b0; #1;
      check_req("tgt200", 1'b1, 32'h200);

      // Branch to 0x300 while holding
      imem_ack = 1'b1; freeze = 1'b1; imem_rdata = 32'hE000_0200; #1;
      check_valid("f200", 32'hE000_0200, 32'h204);
      cyc();
      imem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h300; #1;
      check_req("br_hold", 1'b0, 32'h0);
      check_bubble("br_hold");
      cyc();
      branch_taken = 1'b0; freeze = 1'b0; #1;
      check_req("tgt300", 1'b1, 32'h300);
      imem_ack = 1'b1; imem_rdata = 32'hE000_0300; #1;
      check_valid("f300", 32'hE000_0300, 32'h304);
      cyc();

      // Reset arriving while draining
      imem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h400; #1;
      cyc();
      branch_taken = 1'b0; #1;
      check_req("in_drain", 1'b1, 32'h304);
      rst = 1'b1; #1;
      check("rstdr_req", 32'(imem_req), 32'h0);
      check("rstdr_addr", imem_addr, 32'h0);
      check_bubble("rstdr");
      cyc();
      rst = 1'b0; #1;
      check("rstdr_rel", 32'(imem_req), 32'h0);
      cyc(); #1;
      check_req("rstdr_req0", 1'b1, 32'h0);

      // Three-cycle memory latency at address 0
      for (int i = 0; i < 2; i++) begin
         #1;
         check_req("lat_wait", 1'b1, 32'h0);
         check_bubble("lat_wait");
         cyc();
      end
      imem_ack = 1'b1; imem_rdata = 32'hE000_0000; #1;
      check_req("lat_ack", 1'b1, 32'h0);
      check_valid("lat_ack", 32'hE000_0000, 32'h4);
      cyc();

      // PC wraparound at the top of the address space
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC; #1;
      check_bubble("wrap_br");
      cyc();
      branch_taken = 1'b0; imem_rdata = 32'hE000_FFFC; #1;
      check_req("wrap", 1'b1, 32'hFFFF_FFFC);
      check_valid("wrap", 32'hE000_FFFC, 32'h0);
      cyc();
      imem_ack = 1'b0; #1;
      check_req("wrap_next", 1'b1, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
